mult_sequencer: RTL



---
 rtl/mult_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: request/result sequencer wrapped around an external iterative shift-add multiplier.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   op_valid/op_ready      request handshake; op_a, op_b, op_signed, op_tag are the request payload
//   mul_start              one-cycle start pulse to the multiplier
//   mul_multiplicand/_multiplier  operands held for the multiplier
//   mul_product, mul_ready 2W-bit product and idle/done flag from the multiplier
//   res_valid/res_ready    result handshake; res_product, res_tag are the head of a 2-entry buffer
// Build option: define MULT_SIGNED_EN to honour op_signed (magnitude multiply, then negate the product).
`ifndef WIDTH
`define WIDTH 32
`endif

module mult_sequencer #(
    parameter int WIDTH = `WIDTH,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               op_signed,
    input  logic [TAG_W-1:0]   op_tag,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic [TAG_W-1:0]   res_tag
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t             state;
    logic [TAG_W-1:0]   tag_q;
    logic [2*WIDTH-1:0] prod_mem [2];
    logic [TAG_W-1:0]   tag_mem [2];
    logic               wp, rp;
    logic [1:0]         count;
    logic               accept, push, pop;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [2*WIDTH-1:0] prod_in;

    // mul_ready gates issue so a multiplier left busy by a reset never sees a start
    assign op_ready    = !rst && state == IDLE && mul_ready && count < 2'd2;
    assign accept      = op_valid && op_ready;
    assign push        = state == WAIT && mul_ready;
    assign pop         = res_valid && res_ready;
    assign res_valid   = count != 2'd0;
    assign res_product = prod_mem[rp];
    assign res_tag     = tag_mem[rp];

`ifdef MULT_SIGNED_EN
    logic neg_q, sa, sb;
    assign sa      = op_signed && op_a[WIDTH-1];
    assign sb      = op_signed && op_b[WIDTH-1];
    // W-bit negate: the most negative value maps to 2^(W-1), still valid as unsigned
    assign a_in    = sa ? -op_a : op_a;
    assign b_in    = sb ? -op_b : op_b;
    assign prod_in = neg_q ? -mul_product : mul_product;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            neg_q <= 1'b0;
        else if (accept)
            neg_q <= sa ^ sb;
`else
    logic unused_signed;
    assign unused_signed = op_signed;
    assign a_in          = op_a;
    assign b_in          = op_b;
    assign prod_in       = mul_product;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state            <= IDLE;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            tag_q            <= '0;
            prod_mem[0]      <= '0;
            prod_mem[1]      <= '0;
            tag_mem[0]       <= '0;
            tag_mem[1]       <= '0;
            wp               <= 1'b0;
            rp               <= 1'b0;
            count            <= 2'd0;
        end else begin
            state     <= accept ? ISSUE : state == ISSUE ? WAIT : push ? IDLE : state;
            mul_start <= accept;
            if (accept) begin
                mul_multiplicand <= a_in;
                mul_multiplier   <= b_in;
                tag_q            <= op_tag;
            end
            if (push) begin
                prod_mem[wp] <= prod_in;
                tag_mem[wp]  <= tag_q;
                wp           <= !wp;
            end
            if (pop)
                rp <= !rp;
            count <= count + 2'(push) - 2'(pop);
        end
endmodule
